// File: rtl/eeprom_loader.sv
// eeprom_loader: boot-time copy engine between the AT93C86A EEPROM reader and
// program RAM. Holds the CPU in halt, reads 2*WORD_COUNT bytes sequentially,
// packs byte pairs high-byte-first into 16-bit words, writes them starting at
// BASE_ADDRESS, then releases the CPU.
//
// Optional feature macro: EEPROM_LOADER_CHECKSUM_EN
//   defined   : 16-bit running sum of all written words; a non-zero total
//               raises checksum_error on entry to DONE and keeps cpu_halt high.
//   undefined : no summing logic, checksum_error tied low.
//
// Handshakes (all level-based, the reader runs on a divided clock):
//   Reader: eeprom_strobe is held high in REQUEST with eeprom_address stable
//   until the reader drops eeprom_ready (request accepted). eeprom_data is
//   taken on the first clk eeprom_ready is seen high again after acceptance.
//   RAM: mem_write_enable is a single-clk pulse with mem_address and
//   mem_write_data stable during that clk; the RAM never back-pressures.
//   dbg_state exposes the FSM state encoding for observation.
module eeprom_loader #(
    parameter int unsigned WORD_COUNT   = 1024,
    parameter logic [15:0] BASE_ADDRESS = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] eeprom_address,
    output logic        eeprom_strobe,
    input  logic        eeprom_ready,
    input  logic [7:0]  eeprom_data,
    output logic [15:0] mem_address,
    output logic [15:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        cpu_halt,
    output logic        done,
    output logic        checksum_error,
    output logic [2:0]  dbg_state
);

    localparam logic [10:0] LAST_WORD = 11'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_REQUEST   = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_CAPTURE   = 3'd3,
        S_WRITE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        ready_seen_q, ready_seen_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [10:0] word_cnt_q, word_cnt_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  high_byte_q, high_byte_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        last_word;
    logic        release_ok;

    assign last_word = (word_cnt_q == LAST_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one byte per WAIT_IDLE..CAPTURE pass, WRITE after odd bytes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_IDLE: begin
                // reader must look idle on two consecutive clks
                if (eeprom_ready && ready_seen_q) begin
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (!eeprom_ready) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (eeprom_ready) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = byte_cnt_q[0] ? S_WRITE : S_WAIT_IDLE;
            end
            S_WRITE: begin
                state_d = last_word ? S_DONE : S_WAIT_IDLE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_WAIT_IDLE;
            end
        endcase
    end

    // Datapath next values: idle filter, byte/word counters, packing, RAM address
    always_comb begin
        ready_seen_d = (state_q == S_WAIT_IDLE) && eeprom_ready;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        addr_d       = addr_q;
        high_byte_d  = high_byte_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            S_WAIT_IDLE: begin
                // address is settled before strobe rises and held through REQUEST
                addr_d = byte_cnt_q;
            end
            S_CAPTURE: begin
                if (byte_cnt_q[0]) begin
                    wdata_d = {high_byte_q, eeprom_data};
                end else begin
                    high_byte_d = eeprom_data;
                end
                byte_cnt_d = byte_cnt_q + 11'd1;
            end
            S_WRITE: begin
                // RAM address wraps naturally at 16 bits
                mem_addr_d = mem_addr_q + 16'd1;
                word_cnt_d = word_cnt_q + 11'd1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_seen_q <= 1'b0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            addr_q       <= '0;
            high_byte_q  <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= BASE_ADDRESS;
        end else begin
            ready_seen_q <= ready_seen_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            addr_q       <= addr_d;
            high_byte_q  <= high_byte_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

`ifdef EEPROM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d, sum_next;
    logic        cks_err_q, cks_err_d;

    // Running sum of written words; verdict latched with the last word's write
    always_comb begin
        sum_next  = sum_q + wdata_q;
        sum_d     = sum_q;
        cks_err_d = cks_err_q;
        if (state_q == S_WRITE) begin
            sum_d = sum_next;
            if (last_word) begin
                cks_err_d = (sum_next != 16'h0000);
            end
        end
    end

    // Checksum registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= '0;
            cks_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            cks_err_q <= cks_err_d;
        end
    end

    assign checksum_error = cks_err_q;
    assign release_ok     = ~cks_err_q;
`else
    assign checksum_error = 1'b0;
    assign release_ok     = 1'b1;
`endif

    // Output decode: strobe only in REQUEST, write pulse only in WRITE
    always_comb begin
        eeprom_strobe    = (state_q == S_REQUEST);
        mem_write_enable = (state_q == S_WRITE);
        done             = (state_q == S_DONE);
        cpu_halt         = !((state_q == S_DONE) && release_ok);
    end

    assign eeprom_address = addr_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = wdata_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_eeprom_loader.sv
// Bench for eeprom_loader: four loader instances (different WORD_COUNT and
// BASE_ADDRESS) each driven by a slow EEPROM reader model. Build with
// EEPROM_LOADER_CHECKSUM_EN defined to cover the checksum variant.
module tb_eeprom_loader;

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_REQUEST   = 3'd1;
  localparam logic [2:0] ST_WAIT_DATA = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [4];
  logic        mdl_rst;
  logic [10:0] ee_addr [4];
  logic        ee_strobe [4];
  logic        ee_ready [4];
  logic [7:0]  ee_data [4];
  logic [15:0] mem_addr [4];
  logic [15:0] mem_wdata [4];
  logic        mem_we [4];
  logic        halt_w [4];
  logic        done_w [4];
  logic        cks_w [4];
  logic [2:0]  dbg [4];
  logic [10:0] mdl_lat [4];

  int          checks;
  int          failures;
  int          wr_cnt [4];
  logic        we_prev [4];
  int          hold_addr [4];
  bit          d_bad;
  int          n;
  logic [15:0] exp_sum [4];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  logic [31:0] exp_q3[$];

  // ---------------- DUTs ----------------
  eeprom_loader #(.WORD_COUNT(2), .BASE_ADDRESS(16'h0100)) u_a (
    .clk(clk), .reset(rst[0]), .eeprom_address(ee_addr[0]), .eeprom_strobe(ee_strobe[0]),
    .eeprom_ready(ee_ready[0]), .eeprom_data(ee_data[0]), .mem_address(mem_addr[0]),
    .mem_write_data(mem_wdata[0]), .mem_write_enable(mem_we[0]), .cpu_halt(halt_w[0]),
    .done(done_w[0]), .checksum_error(cks_w[0]), .dbg_state(dbg[0]));

  eeprom_loader #(.WORD_COUNT(1024), .BASE_ADDRESS(16'h0200)) u_b (
    .clk(clk), .reset(rst[1]), .eeprom_address(ee_addr[1]), .eeprom_strobe(ee_strobe[1]),
    .eeprom_ready(ee_ready[1]), .eeprom_data(ee_data[1]), .mem_address(mem_addr[1]),
    .mem_write_data(mem_wdata[1]), .mem_write_enable(mem_we[1]), .cpu_halt(halt_w[1]),
    .done(done_w[1]), .checksum_error(cks_w[1]), .dbg_state(dbg[1]));

  eeprom_loader #(.WORD_COUNT(2), .BASE_ADDRESS(16'hFFFF)) u_c (
    .clk(clk), .reset(rst[2]), .eeprom_address(ee_addr[2]), .eeprom_strobe(ee_strobe[2]),
    .eeprom_ready(ee_ready[2]), .eeprom_data(ee_data[2]), .mem_address(mem_addr[2]),
    .mem_write_data(mem_wdata[2]), .mem_write_enable(mem_we[2]), .cpu_halt(halt_w[2]),
    .done(done_w[2]), .checksum_error(cks_w[2]), .dbg_state(dbg[2]));

  eeprom_loader #(.WORD_COUNT(3), .BASE_ADDRESS(16'h0040)) u_d (
    .clk(clk), .reset(rst[3]), .eeprom_address(ee_addr[3]), .eeprom_strobe(ee_strobe[3]),
    .eeprom_ready(ee_ready[3]), .eeprom_data(ee_data[3]), .mem_address(mem_addr[3]),
    .mem_write_data(mem_wdata[3]), .mem_write_enable(mem_we[3]), .cpu_halt(halt_w[3]),
    .done(done_w[3]), .checksum_error(cks_w[3]), .dbg_state(dbg[3]));

  // ---------------- EEPROM images ----------------
  function automatic logic [7:0] image_byte(input int inst, input logic [10:0] a, input bit bad);
    logic [7:0] b;
    b = 8'h00;
    case (inst)
      0: case (a[1:0])
           2'd0: b = 8'h12;
           2'd1: b = 8'h34;
           2'd2: b = 8'hAB;
           default: b = 8'hCD;
         endcase
      1: b = a[7:0];
      2: case (a[1:0])
           2'd0: b = 8'h5A;
           2'd1: b = 8'hA5;
           2'd2: b = 8'h3C;
           default: b = 8'hC3;
         endcase
      default: case (a)
           11'd0, 11'd1: b = 8'h11;
           11'd2, 11'd3: b = 8'h22;
           11'd4: b = 8'hCC;
           default: b = bad ? 8'hCC : 8'hCD;
         endcase
    endcase
    return b;
  endfunction

  // ---------------- reader models (accept/complete on divided-clock ticks) ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_mdl
    localparam int DIV = (gi == 1) ? 2 : 16;
    logic [4:0]  divc;
    logic [1:0]  mst;
    logic [10:0] lat;
    logic        rdy;
    logic [7:0]  dat;
    int          hold;
    logic        tick_en;
    assign tick_en = (divc == 5'(DIV - 1));
    always @(posedge clk) begin
      if (mdl_rst) begin
        divc <= '0; mst <= 2'd0; lat <= '0; rdy <= 1'b1; dat <= 8'h00; hold <= 0;
      end else begin
        divc <= tick_en ? 5'd0 : divc + 5'd1;
        case (mst)
          2'd0: if (tick_en && ee_strobe[gi]) begin
                  mst <= 2'd1; rdy <= 1'b0; dat <= 8'hEE; lat <= ee_addr[gi];
                  hold <= (int'(ee_addr[gi]) == hold_addr[gi]) ? 50 : 0;
                end
          2'd1: if (tick_en) mst <= 2'd2;
          default: if (hold == 0) begin
                  rdy <= 1'b1; dat <= image_byte(gi, lat, d_bad); mst <= 2'd0;
                end else begin
                  hold <= hold - 1;
                end
        endcase
      end
    end
    assign ee_ready[gi] = rdy;
    assign ee_data[gi]  = dat;
    assign mdl_lat[gi]  = lat;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [15:0] a, input logic [15:0] d);
    case (i)
      0: exp_q0.push_back({a, d});
      1: exp_q1.push_back({a, d});
      2: exp_q2.push_back({a, d});
      default: exp_q3.push_back({a, d});
    endcase
    exp_sum[i] = exp_sum[i] + d;
  endtask

  task automatic clear_exp(input int i);
    case (i)
      0: exp_q0.delete();
      1: exp_q1.delete();
      2: exp_q2.delete();
      default: exp_q3.delete();
    endcase
    exp_sum[i] = 16'h0000;
  endtask

  task automatic pop_exp(input int i, output bit ok, output logic [31:0] v);
    ok = 1'b0;
    v  = '0;
    case (i)
      0: if (exp_q0.size() > 0) begin v = exp_q0.pop_front(); ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin v = exp_q1.pop_front(); ok = 1'b1; end
      2: if (exp_q2.size() > 0) begin v = exp_q2.pop_front(); ok = 1'b1; end
      default: if (exp_q3.size() > 0) begin v = exp_q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  function automatic logic exp_cks(input int i);
`ifdef EEPROM_LOADER_CHECKSUM_EN
    return (exp_sum[i] != 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Write / strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    bit          ok;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      if (ee_strobe[i]) check("strobe_outside_request", 32'(dbg[i]), 32'(ST_REQUEST));
      if (mem_we[i]) begin
        check("we_single_pulse", 32'(we_prev[i]), 32'd0);
        pop_exp(i, ok, v);
        check("write_expected_present", 32'(ok), 32'd1);
        if (ok) check("write_addr_data", {mem_addr[i], mem_wdata[i]}, v);
        wr_cnt[i]++;
      end
      we_prev[i] = mem_we[i];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    failures = 0;
    d_bad = 1'b0;
    hold_addr = '{1, -1, -1, -1};
    mdl_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; wr_cnt[i] = 0; we_prev[i] = 1'b0; exp_sum[i] = 16'h0000;
    end
    repeat (4) tick();

    // reset values
    check("rst_strobe", 32'(ee_strobe[0]), 32'd0);
    check("rst_eeprom_addr", 32'(ee_addr[0]), 32'd0);
    check("rst_we", 32'(mem_we[0]), 32'd0);
    check("rst_mem_addr_a", 32'(mem_addr[0]), 32'h0100);
    check("rst_mem_addr_c", 32'(mem_addr[2]), 32'hFFFF);
    check("rst_wdata", 32'(mem_wdata[0]), 32'd0);
    check("rst_halt", 32'(halt_w[0]), 32'd1);
    check("rst_done", 32'(done_w[0]), 32'd0);
    check("rst_cks", 32'(cks_w[0]), 32'd0);
    check("rst_state", 32'(dbg[0]), 32'(ST_WAIT_IDLE));

    // expected images
    push_exp(0, 16'h0100, 16'h1234);
    push_exp(0, 16'h0101, 16'hABCD);
    for (int k = 0; k < 1024; k++) push_exp(1, 16'h0200 + 16'(k), {8'(2 * k), 8'(2 * k + 1)});
    push_exp(2, 16'hFFFF, 16'h5AA5);
    push_exp(2, 16'h0000, 16'h3CC3);
    push_exp(3, 16'h0040, 16'h1111);
    push_exp(3, 16'h0041, 16'h2222);
    push_exp(3, 16'h0042, 16'hCCCD);

    mdl_rst = 1'b0;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // slow reader: byte 1 of instance A held busy for 50 extra clks
    for (n = 0; n < 2000 && !(ee_ready[0] == 1'b0 && mdl_lat[0] == 11'd1); n++) tick();
    check("hold_accept_seen", 32'(ee_ready[0] == 1'b0 && mdl_lat[0] == 11'd1), 32'd1);
    tick();
    for (int c = 0; c < 50; c++) begin
      check("hold_no_strobe", 32'(ee_strobe[0]), 32'd0);
      check("hold_no_write", 32'(mem_we[0]), 32'd0);
      check("hold_state", 32'(dbg[0]), 32'(ST_WAIT_DATA));
      tick();
    end
    hold_addr[0] = -1;

    for (n = 0; n < 60000 && !(done_w[0] && done_w[1] && done_w[2] && done_w[3]); n++) tick();
    check("all_done_in_budget", 32'(done_w[0] && done_w[1] && done_w[2] && done_w[3]), 32'd1);
    repeat (20) tick();
    for (int i = 0; i < 4; i++) begin
      check("final_done", 32'(done_w[i]), 32'd1);
      check("final_halt", 32'(halt_w[i]), 32'(exp_cks(i)));
      check("final_cks", 32'(cks_w[i]), 32'(exp_cks(i)));
      check("final_queue_empty", 32'(qsize(i)), 32'd0);
    end
    check("write_count_a", 32'(wr_cnt[0]), 32'd2);
    check("write_count_b", 32'(wr_cnt[1]), 32'd1024);
    check("write_count_c", 32'(wr_cnt[2]), 32'd2);
    check("write_count_d", 32'(wr_cnt[3]), 32'd3);
    check("last_byte_addr_b", 32'(mdl_lat[1]), 32'h7FF);

    // corrupted checksum word on instance D
    clear_exp(3);
    d_bad = 1'b1;
    push_exp(3, 16'h0040, 16'h1111);
    push_exp(3, 16'h0041, 16'h2222);
    push_exp(3, 16'h0042, 16'hCCCC);
    wr_cnt[3] = 0;
    rst[3] = 1'b1;
    tick();
    tick();
    rst[3] = 1'b0;
    for (n = 0; n < 2000 && !done_w[3]; n++) tick();
    check("bad_cks_done", 32'(done_w[3]), 32'd1);
    tick();
`ifdef EEPROM_LOADER_CHECKSUM_EN
    check("bad_cks_error", 32'(cks_w[3]), 32'd1);
    check("bad_cks_halt", 32'(halt_w[3]), 32'd1);
`else
    check("bad_cks_error", 32'(cks_w[3]), 32'd0);
    check("bad_cks_halt", 32'(halt_w[3]), 32'd0);
`endif
    check("bad_cks_writes", 32'(wr_cnt[3]), 32'd3);

    // reset landing in WAIT_DATA of byte 3 on instance A
    clear_exp(0);
    push_exp(0, 16'h0100, 16'h1234);
    push_exp(0, 16'h0101, 16'hABCD);
    wr_cnt[0] = 0;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    for (n = 0; n < 2000 && !(dbg[0] == ST_WAIT_DATA && ee_addr[0] == 11'd3 && !ee_ready[0]); n++) tick();
    check("mid_read_reached", 32'(dbg[0] == ST_WAIT_DATA && ee_addr[0] == 11'd3 && !ee_ready[0]), 32'd1);
    clear_exp(0);
    push_exp(0, 16'h0100, 16'h1234);
    push_exp(0, 16'h0101, 16'hABCD);
    wr_cnt[0] = 0;
    rst[0] = 1'b1;
    tick();
    check("mid_rst_state", 32'(dbg[0]), 32'(ST_WAIT_IDLE));
    check("mid_rst_strobe", 32'(ee_strobe[0]), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr[0]), 32'h0100);
    rst[0] = 1'b0;
    for (n = 0; n < 200 && !ee_ready[0]; n++) begin
      check("busy_no_strobe", 32'(ee_strobe[0]), 32'd0);
      tick();
    end
    check("reader_idle_again", 32'(ee_ready[0]), 32'd1);
    for (n = 0; n < 100 && !ee_strobe[0]; n++) tick();
    check("restart_idle_cycles", 32'(n), 32'd2);
    check("restart_addr", 32'(ee_addr[0]), 32'd0);
    for (n = 0; n < 2000 && !done_w[0]; n++) tick();
    check("restart_done", 32'(done_w[0]), 32'd1);
    tick();
    check("restart_writes", 32'(wr_cnt[0]), 32'd2);
    check("restart_queue_empty", 32'(qsize(0)), 32'd0);
    check("restart_halt", 32'(halt_w[0]), 32'(exp_cks(0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
